// File: rtl/decoder_scan_ctrl.sv
// Scan controller for a 3-to-8 decoder: steps sel through 0..7 (or 7..0),
// holding each index for dwell+1 cycles, in continuous or one-shot mode.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] CNT_ZERO = '0;

  logic [1:0]         state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic [2:0] final_idx;
  logic [2:0] next_idx;

  // The last index of a sweep depends on direction; 3-bit math gives the wrap.
  assign final_idx = dir_q ? 3'd0 : 3'd7;
  assign next_idx  = dir_q ? (sel_q - 3'd1) : (sel_q + 3'd1);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    dwell_d     = dwell_q;

    case (state_q)
      S_IDLE: begin
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start && !stop) begin
          state_d     = S_RUN;
          mode_d      = mode;
          dir_d       = dir;
          dwell_d     = dwell;
          sel_d       = dir ? 3'd7 : 3'd0;
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = CNT_ZERO;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d     = S_IDLE;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = CNT_ZERO;
        end else if (cnt_q == dwell_q) begin
          cnt_d = CNT_ZERO;
          if (mode_q && (sel_q == final_idx)) begin
            state_d     = S_DONE;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            sel_d  = next_idx;
            wrap_d = !mode_q && (sel_q == final_idx);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= CNT_ZERO;
      mode_q      <= 1'b0;
      dir_q       <= 1'b0;
      dwell_q     <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      dwell_q     <= dwell_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: the driver queues the expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [2:0] sel;
  logic       sel_valid, busy, wrap, done;

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .dir(dir), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
    .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] sel;
    logic       v, b, w, d;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive inputs just after an edge; they are registered on the next edge.
  task automatic tick(input logic r, input logic s, input logic p,
                      input logic m, input logic dr, input logic [7:0] dw);
    @(posedge clk);
    #1;
    rst = r; start = s; stop = p; mode = m; dir = dr; dwell = dw;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic expect_out(input logic [2:0] s, input logic v, input logic b,
                            input logic w, input logic d);
    exp_t e;
    e.due = cyc + 1; e.sel = s; e.v = v; e.b = b; e.w = w; e.d = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (e.due != cyc ||
          {sel, sel_valid, busy, wrap, done} !== {e.sel, e.v, e.b, e.w, e.d}) begin
        miscompares++;
        $display("FAIL cyc%0d out: got sel=%0d v=%b b=%b w=%b d=%b, need sel=%0d v=%b b=%b w=%b d=%b",
                 cyc, sel, sel_valid, busy, wrap, done, e.sel, e.v, e.b, e.w, e.d);
      end else begin
        $display("cyc%0d sel=%0d v=%b b=%b w=%b d=%b ok", cyc, sel, sel_valid, busy, wrap, done);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); expect_out(3'd0, 0, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0); expect_out(3'd0, 0, 0, 0, 0);
    idle();                                   expect_out(3'd0, 0, 0, 0, 0);

    // One-shot up, dwell 0
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0); expect_out(3'd0, 1, 1, 0, 0);
    for (int i = 1; i < 8; i++) begin
      idle(); expect_out(i[2:0], 1, 1, 0, 0);
    end
    idle(); expect_out(3'd7, 0, 0, 0, 1);
    idle(); expect_out(3'd7, 0, 0, 0, 0);
    idle(); expect_out(3'd7, 0, 0, 0, 0);

    // One-shot down, dwell 9: 80 busy cycles, start during DONE ignored
    for (int n = 0; n < 80; n++) begin
      if (n == 0) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd9);
      else        idle();
      expect_out(3'd7 - 3'(n / 10), 1, 1, 0, 0);
    end
    idle(); expect_out(3'd0, 0, 0, 0, 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); expect_out(3'd0, 0, 0, 0, 0);
    idle(); expect_out(3'd0, 0, 0, 0, 0);

    // Continuous up, dwell 1: wrap every 16 cycles, then stop at sel=3
    for (int n = 0; n < 40; n++) begin
      if (n == 0) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
      else        idle();
      expect_out(3'((n / 2) % 8), 1, 1, (n > 0) && (n % 16 == 0), 0);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); expect_out(3'd3, 0, 0, 0, 0);
    idle(); expect_out(3'd3, 0, 0, 0, 0);

    // Start and stop together in IDLE stays idle
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0); expect_out(3'd3, 0, 0, 0, 0);
    idle(); expect_out(3'd3, 0, 0, 0, 0);

    // One-shot up, dwell 2; a new start mid-scan must not disturb timing
    for (int n = 0; n < 24; n++) begin
      if (n == 0)      tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
      else if (n == 4) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
      else             idle();
      expect_out(3'(n / 3), 1, 1, 0, 0);
    end
    idle(); expect_out(3'd7, 0, 0, 0, 1);
    idle(); expect_out(3'd7, 0, 0, 0, 0);

    // Stop while sel=3 in a one-shot scan
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0); expect_out(3'd0, 1, 1, 0, 0);
    for (int i = 1; i < 4; i++) begin
      idle(); expect_out(i[2:0], 1, 1, 0, 0);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); expect_out(3'd3, 0, 0, 0, 0);
    idle(); expect_out(3'd3, 0, 0, 0, 0);
    idle(); expect_out(3'd3, 0, 0, 0, 0);

    // Reset mid-scan at sel=5 (with start high) then clean restart
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0); expect_out(3'd7, 1, 1, 0, 0);
    for (int i = 1; i < 3; i++) begin
      idle(); expect_out(3'd7 - i[2:0], 1, 1, 0, 0);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); expect_out(3'd0, 0, 0, 0, 0);
    idle(); expect_out(3'd0, 0, 0, 0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0); expect_out(3'd0, 1, 1, 0, 0);
    for (int i = 1; i < 8; i++) begin
      idle(); expect_out(i[2:0], 1, 1, 0, 0);
    end
    idle(); expect_out(3'd7, 0, 0, 0, 1);
    idle(); expect_out(3'd7, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, giving the width of the dwell count.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a scan, sampled on each clk edge.
REQ-005 The block SHALL have port stop, input, 1 bit, a request to abort a scan.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = continuous, 1 = one-shot; latched at start.
REQ-007 The block SHALL have port dir, input, 1 bit: 0 = up (0..7), 1 = down (7..0); latched at start.
REQ-008 The block SHALL have port dwell, input, DWELL_W bits, giving the cycles per index minus 1; latched at start.
REQ-009 The block SHALL have port sel, output, 3 bits, the select index that drives the 3-to-8 decoder input w.
REQ-010 The block SHALL have port sel_valid, output, 1 bit, high while sel is an active scan index.
REQ-011 The block SHALL have port busy, output, 1 bit, high while in RUN.
REQ-012 The block SHALL have port wrap, output, 1 bit, a one-cycle pulse on continuous-mode wrap-around.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse on one-shot completion.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 IDLE: start=1 and stop=0 SHALL cause, on the next cycle, state RUN with mode/dir/dwell latched, sel = 0 (up) or 7 (down), sel_valid=1, busy=1, dwell counter 0.
REQ-016 start and stop both high in IDLE SHALL leave the block in IDLE (stop has priority).
REQ-017 RUN: each index SHALL be held for exactly dwell_lat+1 cycles; dwell_lat=0 SHALL give one cycle per index.
REQ-018 RUN: the dwell counter SHALL increment each cycle; in the cycle where counter==dwell_lat, counter SHALL return to 0 and sel SHALL advance on the next cycle.
REQ-019 Index arithmetic SHALL be 3-bit modulo-8: up 7->0, down 0->7.
REQ-020 Continuous mode: wrap SHALL be 1 for exactly the first cycle of the wrapped index (0 when up, 7 when down), and scanning SHALL continue without gap.
REQ-021 One-shot mode: when the dwell of the final index (7 up, 0 down) expires, the next cycle SHALL be state DONE with done=1, busy=0, sel_valid=0 and sel holding the final index; DONE SHALL return to IDLE after one cycle.
REQ-022 stop=1 in RUN SHALL cause, on the next cycle, state IDLE with busy=0 and sel_valid=0, sel holding its last value, and no done or wrap pulse.
REQ-023 start=1 during RUN or DONE SHALL be ignored; latched parameters SHALL not change mid-scan.
REQ-024 In IDLE, sel SHALL hold its last value and sel_valid, busy, wrap and done SHALL be 0.
REQ-025 wrap and done SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 SHALL, on the clock edge, force state IDLE, sel=3'b000, sel_valid=0, busy=0, wrap=0, done=0, dwell counter 0 and latched parameters 0.
REQ-027 rst SHALL override start and stop in the same cycle and SHALL abort any scan in RUN or DONE with no done pulse.
REQ-028 The first start after rst deasserts SHALL behave per REQ-015.

Verification
REQ-029 Bench: mode=1, dir=0, dwell=0, start pulse -> sel 0,1,...,7 on eight consecutive cycles with sel_valid=1, then done=1 for one cycle, then IDLE.
REQ-030 Bench: mode=1, dir=1, dwell=9 -> each index 7..0 held exactly 10 cycles, total busy = 80 cycles, then a single done pulse.
REQ-031 Bench: mode=0, dir=0, dwell=1 -> sel 0,0,1,1,...,7,7,0,... with wrap=1 only on the first cycle of each return to 0 (every 16 cycles) and done never asserted.
REQ-032 Bench: stop asserted while sel=3 in RUN -> next cycle busy=0, sel_valid=0, sel=3, and done=0 and wrap=0 throughout.
REQ-033 Bench: start and stop high together in IDLE -> stays IDLE; start pulse during RUN with new dwell -> ignored, dwell timing unchanged.
REQ-034 Bench: rst asserted mid-scan at sel=5 -> next cycle sel=0 and all flags 0; a later start restarts cleanly from 0 (up) per REQ-015.
